// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared types and constants for the Fibonacci frame stack
package fib_pkg;

   typedef enum logic [3:0] {
      IDLE,
      PUSH0,
      PUSH1,
      PUSH2,
      POP0,
      POP1,
      POP2,
      POPW,
      DONE
   } stack_state_t;

   localparam int FRAME_WORDS = 3;

   localparam logic [1:0] FLD_N    = 2'd0;
   localparam logic [1:0] FLD_FLAG = 2'd1;
   localparam logic [1:0] FLD_RES  = 2'd2;

endpackage

// File: rtl/fib_stack_if.sv
// rtl/fib_stack_if.sv - request/response bundle between recursion controller and frame stack
interface fib_stack_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   localparam int DW = $clog2(DEPTH + 1);

   logic             pushSig;
   logic             popSig;
   logic [WIDTH-1:0] n_in;
   logic [WIDTH-1:0] flag_in;
   logic [WIDTH-1:0] res_in;
   logic [WIDTH-1:0] n_out;
   logic [WIDTH-1:0] flag_out;
   logic [WIDTH-1:0] res_out;
   logic             readySig;
   logic [DW-1:0]    depth;
   logic             empty;
   logic             full;
   logic             err;

   modport master (
      output pushSig, popSig, n_in, flag_in, res_in,
      input  n_out, flag_out, res_out, readySig, depth, empty, full, err
   );

   modport slave (
      input  pushSig, popSig, n_in, flag_in, res_in,
      output n_out, flag_out, res_out, readySig, depth, empty, full, err
   );
endinterface

// File: rtl/fib_stack_ram.sv
// rtl/fib_stack_ram.sv - single-port frame RAM, sync write, 1-cycle sync read, no reset
module fib_stack_ram
   import fib_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int WORDS = FRAME_WORDS * DEPTH,
   localparam int AW    = $clog2(WORDS)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end
endmodule

// File: rtl/fib_stack.sv
// rtl/fib_stack.sv - recursion frame stack {n, flag, res} serialized into a word-wide RAM
// Optional sticky overflow/underflow flag enabled by FIB_STACK_ERR_EN.
module fib_stack
   import fib_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input logic       clk,
   input logic       rst,
   fib_stack_if.slave bus
);
   localparam int SPW = $clog2(DEPTH + 1);
   localparam int AW  = $clog2(FRAME_WORDS * DEPTH);

   stack_state_t     state, state_nxt;
   logic [SPW-1:0]   sp;
   logic [WIDTH-1:0] fr_n, fr_flag, fr_res;
   logic [WIDTH-1:0] n_q, flag_q, res_q;
   logic             is_full, is_empty;
   logic             ram_we, is_pop_st, ready;
   logic [1:0]       fld;
   logic [SPW-1:0]   sp_sel;
   logic [AW-1:0]    ram_addr;
   logic [WIDTH-1:0] ram_wdata, ram_rdata;

   assign is_full  = (sp == SPW'(DEPTH));
   assign is_empty = (sp == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.pushSig) begin
               state_nxt = PUSH0;
            end else if (bus.popSig) begin
               state_nxt = POP0;
            end
         end
         PUSH0:   state_nxt = PUSH1;
         PUSH1:   state_nxt = PUSH2;
         PUSH2:   state_nxt = DONE;
         POP0:    state_nxt = POP1;
         POP1:    state_nxt = POP2;
         POP2:    state_nxt = POPW;
         POPW:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ram_we    = 1'b0;
      is_pop_st = 1'b0;
      ready     = 1'b0;
      fld       = FLD_N;
      ram_wdata = fr_n;
      case (state)
         PUSH0: begin
            ram_we = !is_full;
         end
         PUSH1: begin
            ram_we    = !is_full;
            fld       = FLD_FLAG;
            ram_wdata = fr_flag;
         end
         PUSH2: begin
            ram_we    = !is_full;
            fld       = FLD_RES;
            ram_wdata = fr_res;
         end
         POP0: is_pop_st = 1'b1;
         POP1: begin
            is_pop_st = 1'b1;
            fld       = FLD_FLAG;
         end
         POP2: begin
            is_pop_st = 1'b1;
            fld       = FLD_RES;
         end
         DONE:    ready = 1'b1;
         default: ;
      endcase
   end

   // Pops address the top frame (sp-1); an empty pop reads frame 0 and discards the data.
   assign sp_sel   = (is_pop_st && !is_empty) ? sp - SPW'(1) : sp;
   assign ram_addr = AW'(sp_sel) * AW'(FRAME_WORDS) + AW'(fld);

   always_ff @(posedge clk) begin
      if (rst) begin
         sp      <= '0;
         n_q     <= '0;
         flag_q  <= '0;
         res_q   <= '0;
         fr_n    <= '0;
         fr_flag <= '0;
         res_q   <= '0;
         fr_res  <= '0;
      end else begin
         if (state == IDLE && bus.pushSig) begin
            fr_n    <= bus.n_in;
            fr_flag <= bus.flag_in;
            fr_res  <= bus.res_in;
         end
         if (state == PUSH2 && !is_full) begin
            sp <= sp + SPW'(1);
         end
         // RAM data lags the issued address by one cycle.
         if (state == POP1) begin
            n_q <= is_empty ? '0 : ram_rdata;
         end
         if (state == POP2) begin
            flag_q <= is_empty ? '0 : ram_rdata;
         end
         if (state == POPW) begin
            res_q <= is_empty ? '0 : ram_rdata;
            if (!is_empty) begin
               sp <= sp - SPW'(1);
            end
         end
      end
   end

`ifdef FIB_STACK_ERR_EN
   logic err_q, bad_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
         bad_q <= 1'b0;
      end else begin
         if (state == IDLE) begin
            bad_q <= bus.pushSig ? is_full : (bus.popSig & is_empty);
         end
         if (state == DONE && bad_q) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   fib_stack_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   assign bus.readySig = ready;
   assign bus.n_out    = n_q;
   assign bus.flag_out = flag_q;
   assign bus.res_out  = res_q;
   assign bus.depth    = sp;
   assign bus.empty    = is_empty;
   assign bus.full     = is_full;
endmodule
